// File: rtl/chroma_key_pkg.sv
// Shared constants and types for the chroma-key pixel pipeline.
package chroma_key_pkg;

  localparam int DW_DEF    = 10;
  localparam int CNT_W_DEF = 20;

  localparam logic [1:0] CFG_THR_HI = 2'd0;
  localparam logic [1:0] CFG_THR_LO = 2'd1;
  localparam logic [1:0] CFG_MARGIN = 2'd2;
  localparam logic [1:0] CFG_CTRL   = 2'd3;

  localparam int CTRL_KEY_SEL  = 0;
  localparam int CTRL_BLEND_EN = 1;
  localparam int CTRL_BYPASS   = 2;

  localparam logic [9:0] THR_HI_DEF = 10'h1FF;
  localparam logic [9:0] THR_LO_DEF = 10'h1FF;
  localparam logic [9:0] MARGIN_DEF = 10'h040;

  typedef enum logic {
    KEY_GREEN = 1'b0,
    KEY_BLUE  = 1'b1
  } key_sel_e;

  typedef struct packed {
    logic     bypass;
    logic     blend_en;
    key_sel_e key_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{bypass: 1'b0, blend_en: 1'b0, key_sel: KEY_GREEN};

endpackage

// File: rtl/chroma_key_classify.sv
// Combinational pixel classifier: full key match, or key-dominant edge pixel.
// Margin sums are one bit wider so a sum past full scale can never be met by K.
module chroma_key_classify
  import chroma_key_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_red,
  input  logic [DW-1:0] i_green,
  input  logic [DW-1:0] i_blue,
  input  key_sel_e      i_key_sel,
  input  logic [DW-1:0] i_thr_hi,
  input  logic [DW-1:0] i_thr_lo,
  input  logic [DW-1:0] i_margin,
  output logic          o_full,
  output logic          o_edge
);

  logic [DW-1:0] w_k;
  logic [DW-1:0] w_o1;
  logic [DW-1:0] w_o2;
  logic [DW:0]   w_sum1;
  logic [DW:0]   w_sum2;

  always_comb begin
    w_k  = i_green;
    w_o1 = i_red;
    w_o2 = i_blue;
    if (i_key_sel == KEY_BLUE) begin
      w_k  = i_blue;
      w_o2 = i_green;
    end
  end

  assign w_sum1 = {1'b0, w_o1} + {1'b0, i_margin};
  assign w_sum2 = {1'b0, w_o2} + {1'b0, i_margin};

  assign o_full = (w_k > i_thr_hi) && (w_o1 < i_thr_lo) && (w_o2 < i_thr_lo);
  assign o_edge = !o_full && ({1'b0, w_k} >= w_sum1) && ({1'b0, w_k} >= w_sum2);

endmodule

// File: rtl/chroma_key_pipe.sv
// Pipelined chroma-key compositor: 3-cycle valid-to-valid latency, no backpressure,
// config double-buffered to frame start, per-frame saturating keyed-pixel count.
module chroma_key_pipe
  import chroma_key_pkg::*;
#(
  parameter int            DW         = DW_DEF,
  parameter int            CNT_W      = CNT_W_DEF,
  parameter logic [DW-1:0] THR_HI_RST = DW'(THR_HI_DEF),
  parameter logic [DW-1:0] THR_LO_RST = DW'(THR_LO_DEF),
  parameter logic [DW-1:0] MARGIN_RST = DW'(MARGIN_DEF)
) (
  input  logic             iCLK27,
  input  logic             iRST_N,
  input  logic             iVALID,
  input  logic             iSOF,
  input  logic [DW-1:0]    iRed,
  input  logic [DW-1:0]    iGreen,
  input  logic [DW-1:0]    iBlue,
  input  logic [DW-1:0]    imVGA_R,
  input  logic [DW-1:0]    imVGA_G,
  input  logic [DW-1:0]    imVGA_B,
  input  logic             iCFG_WE,
  input  logic [1:0]       iCFG_ADDR,
  input  logic [DW-1:0]    iCFG_DATA,
  output logic             oVALID,
  output logic [DW-1:0]    gsRed,
  output logic [DW-1:0]    gsGreen,
  output logic [DW-1:0]    gsBlue,
  output logic [CNT_W-1:0] oKEY_CNT
);

  logic [DW-1:0] r_sh_thr_hi, r_sh_thr_lo, r_sh_margin;
  logic [DW-1:0] r_act_thr_hi, r_act_thr_lo, r_act_margin;
  ctrl_t         r_sh_ctrl, r_act_ctrl;

  logic          r_s1_vld, r_s1_sof;
  logic [DW-1:0] r_s1_fg_r, r_s1_fg_g, r_s1_fg_b;
  logic [DW-1:0] r_s1_bg_r, r_s1_bg_g, r_s1_bg_b;

  logic          r_s2_vld, r_s2_full, r_s2_edge, r_s2_bypass, r_s2_blend;
  logic [DW-1:0] r_s2_fg_r, r_s2_fg_g, r_s2_fg_b;
  logic [DW-1:0] r_s2_bg_r, r_s2_bg_g, r_s2_bg_b;

  logic             r_o_vld;
  logic [DW-1:0]    r_o_r, r_o_g, r_o_b;
  logic [CNT_W-1:0] r_cnt, r_key_cnt;
  logic             r_in_frame;

  logic          w_full, w_edge, w_hit;
  logic [DW:0]   w_sum_r, w_sum_g, w_sum_b;
  logic [DW-1:0] w_out_r, w_out_g, w_out_b;

  // Shadow is written any time; active only follows it on a valid SOF pixel.
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sh_thr_hi  <= THR_HI_RST;
      r_sh_thr_lo  <= THR_LO_RST;
      r_sh_margin  <= MARGIN_RST;
      r_sh_ctrl    <= CTRL_RST;
      r_act_thr_hi <= THR_HI_RST;
      r_act_thr_lo <= THR_LO_RST;
      r_act_margin <= MARGIN_RST;
      r_act_ctrl   <= CTRL_RST;
    end else begin
      if (iCFG_WE) begin
        case (iCFG_ADDR)
          CFG_THR_HI: r_sh_thr_hi <= iCFG_DATA;
          CFG_THR_LO: r_sh_thr_lo <= iCFG_DATA;
          CFG_MARGIN: r_sh_margin <= iCFG_DATA;
          default:    r_sh_ctrl   <= '{bypass:   iCFG_DATA[CTRL_BYPASS],
                                       blend_en: iCFG_DATA[CTRL_BLEND_EN],
                                       key_sel:  key_sel_e'(iCFG_DATA[CTRL_KEY_SEL])};
        endcase
      end
      if (iVALID && iSOF) begin
        r_act_thr_hi <= r_sh_thr_hi;
        r_act_thr_lo <= r_sh_thr_lo;
        r_act_margin <= r_sh_margin;
        r_act_ctrl   <= r_sh_ctrl;
      end
    end
  end

  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_vld  <= 1'b0;
      r_s1_sof  <= 1'b0;
      r_s1_fg_r <= '0;
      r_s1_fg_g <= '0;
      r_s1_fg_b <= '0;
      r_s1_bg_r <= '0;
      r_s1_bg_g <= '0;
      r_s1_bg_b <= '0;
    end else begin
      r_s1_vld  <= iVALID;
      r_s1_sof  <= iSOF;
      r_s1_fg_r <= iRed;
      r_s1_fg_g <= iGreen;
      r_s1_fg_b <= iBlue;
      r_s1_bg_r <= imVGA_R;
      r_s1_bg_g <= imVGA_G;
      r_s1_bg_b <= imVGA_B;
    end
  end

  chroma_key_classify #(.DW(DW)) u_classify (
    .i_red     (r_s1_fg_r),
    .i_green   (r_s1_fg_g),
    .i_blue    (r_s1_fg_b),
    .i_key_sel (r_act_ctrl.key_sel),
    .i_thr_hi  (r_act_thr_hi),
    .i_thr_lo  (r_act_thr_lo),
    .i_margin  (r_act_margin),
    .o_full    (w_full),
    .o_edge    (w_edge)
  );

  // Mode bits travel with the pixel so an SOF swap never affects pixels already past S2.
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s2_vld    <= 1'b0;
      r_s2_full   <= 1'b0;
      r_s2_edge   <= 1'b0;
      r_s2_bypass <= 1'b0;
      r_s2_blend  <= 1'b0;
      r_s2_fg_r   <= '0;
      r_s2_fg_g   <= '0;
      r_s2_fg_b   <= '0;
      r_s2_bg_r   <= '0;
      r_s2_bg_g   <= '0;
      r_s2_bg_b   <= '0;
    end else begin
      r_s2_vld    <= r_s1_vld;
      r_s2_full   <= w_full;
      r_s2_edge   <= w_edge;
      r_s2_bypass <= r_act_ctrl.bypass;
      r_s2_blend  <= r_act_ctrl.blend_en;
      r_s2_fg_r   <= r_s1_fg_r;
      r_s2_fg_g   <= r_s1_fg_g;
      r_s2_fg_b   <= r_s1_fg_b;
      r_s2_bg_r   <= r_s1_bg_r;
      r_s2_bg_g   <= r_s1_bg_g;
      r_s2_bg_b   <= r_s1_bg_b;
    end
  end

  assign w_sum_r = {1'b0, r_s2_fg_r} + {1'b0, r_s2_bg_r};
  assign w_sum_g = {1'b0, r_s2_fg_g} + {1'b0, r_s2_bg_g};
  assign w_sum_b = {1'b0, r_s2_fg_b} + {1'b0, r_s2_bg_b};

  always_comb begin
    w_out_r = r_s2_fg_r;
    w_out_g = r_s2_fg_g;
    w_out_b = r_s2_fg_b;
    if (!r_s2_bypass) begin
      if (r_s2_full) begin
        w_out_r = r_s2_bg_r;
        w_out_g = r_s2_bg_g;
        w_out_b = r_s2_bg_b;
      end else if (r_s2_edge && r_s2_blend) begin
        w_out_r = w_sum_r[DW:1];
        w_out_g = w_sum_g[DW:1];
        w_out_b = w_sum_b[DW:1];
      end
    end
  end

  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_o_vld <= 1'b0;
      r_o_r   <= '0;
      r_o_g   <= '0;
      r_o_b   <= '0;
    end else begin
      r_o_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_o_r <= w_out_r;
        r_o_g <= w_out_g;
        r_o_b <= w_out_b;
      end
    end
  end

  assign w_hit = r_s1_vld && w_full && !r_act_ctrl.bypass;

  // Nothing is counted until the first SOF after reset opens a frame.
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt      <= '0;
      r_key_cnt  <= '0;
      r_in_frame <= 1'b0;
    end else if (r_s1_vld && r_s1_sof) begin
      r_key_cnt  <= r_cnt;
      r_cnt      <= w_hit ? CNT_W'(1) : '0;
      r_in_frame <= 1'b1;
    end else if (w_hit && r_in_frame && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign oVALID   = r_o_vld;
  assign gsRed    = r_o_r;
  assign gsGreen  = r_o_g;
  assign gsBlue   = r_o_b;
  assign oKEY_CNT = r_key_cnt;

endmodule

// File: tb/tb_chroma_key_pipe.sv
// Bench for chroma_key_pipe: directed scenarios plus random traffic against a behavioural model.
module tb_chroma_key_pipe;
  import chroma_key_pkg::*;

  localparam int DW    = 10;
  localparam int CNT_W = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iVALID = 1'b0, iSOF = 1'b0, iCFG_WE = 1'b0;
  logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic [DW-1:0] imVGA_R = '0, imVGA_G = '0, imVGA_B = '0;
  logic [1:0]    iCFG_ADDR = '0;
  logic [DW-1:0] iCFG_DATA = '0;
  logic          oVALID, oVALID4;
  logic [DW-1:0] gsRed, gsGreen, gsBlue, gsRed4, gsGreen4, gsBlue4;
  logic [CNT_W-1:0] oKEY_CNT;
  logic [3:0]       oKEY_CNT4;

  always #5 clk = ~clk;

  chroma_key_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .iCLK27(clk), .iRST_N(rst_n), .iVALID(iVALID), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .imVGA_R(imVGA_R), .imVGA_G(imVGA_G), .imVGA_B(imVGA_B),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .oVALID(oVALID), .gsRed(gsRed), .gsGreen(gsGreen), .gsBlue(gsBlue),
    .oKEY_CNT(oKEY_CNT)
  );

  chroma_key_pipe #(.DW(DW), .CNT_W(4)) dut4 (
    .iCLK27(clk), .iRST_N(rst_n), .iVALID(iVALID), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .imVGA_R(imVGA_R), .imVGA_G(imVGA_G), .imVGA_B(imVGA_B),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .oVALID(oVALID4), .gsRed(gsRed4), .gsGreen(gsGreen4), .gsBlue(gsBlue4),
    .oKEY_CNT(oKEY_CNT4)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int s_hi, s_lo, s_mg, s_ctrl, a_hi, a_lo, a_mg, a_ctrl;
  int m_cnt, m_kc, m_r, m_g, m_b;
  bit m_in_frame;
  logic [3*DW:0] q_pix[$];
  int            q_kc[$];

  logic [3*DW:0] e_pix, g_pix;
  int            e_kc, g_kc, e_kc4, g_kc4;
  logic [54:0]   snap;

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic model_reset();
    s_hi = 'h1FF; s_lo = 'h1FF; s_mg = 'h040; s_ctrl = 0;
    a_hi = 'h1FF; a_lo = 'h1FF; a_mg = 'h040; a_ctrl = 0;
    m_cnt = 0; m_kc = 0; m_in_frame = 0; m_r = 0; m_g = 0; m_b = 0;
    q_pix.delete(); q_pix.push_back('0); q_pix.push_back('0);
    q_kc.delete();  q_kc.push_back(0);
  endtask

  // Drives one clock of input, advances the model, and samples DUT and expected outputs.
  task automatic step(input bit v, input bit sof, input int fr, input int fgc, input int fb,
                      input int br, input int bgc, input int bb,
                      input bit we, input int addr, input int data);
    int key, o1, o2;
    bit full, edg, byp, bld, hit;
    iVALID = v; iSOF = sof;
    iRed = fr[DW-1:0]; iGreen = fgc[DW-1:0]; iBlue = fb[DW-1:0];
    imVGA_R = br[DW-1:0]; imVGA_G = bgc[DW-1:0]; imVGA_B = bb[DW-1:0];
    iCFG_WE = we; iCFG_ADDR = addr[1:0]; iCFG_DATA = data[DW-1:0];
    if (v && sof) begin
      a_hi = s_hi; a_lo = s_lo; a_mg = s_mg; a_ctrl = s_ctrl;
    end
    if (we) begin
      case (addr)
        0: s_hi = data;
        1: s_lo = data;
        2: s_mg = data;
        default: s_ctrl = data & 7;
      endcase
    end
    if (v) begin
      key = (a_ctrl & 1) ? fb : fgc;
      o1  = fr;
      o2  = (a_ctrl & 1) ? fgc : fb;
      byp = ((a_ctrl >> 2) & 1) != 0;
      bld = ((a_ctrl >> 1) & 1) != 0;
      full = (key > a_hi) && (o1 < a_lo) && (o2 < a_lo);
      edg  = !full && (key >= o1 + a_mg) && (key >= o2 + a_mg);
      if (byp)              begin m_r = fr; m_g = fgc; m_b = fb; end
      else if (full)        begin m_r = br; m_g = bgc; m_b = bb; end
      else if (edg && bld)  begin m_r = (fr + br) / 2; m_g = (fgc + bgc) / 2; m_b = (fb + bb) / 2; end
      else                  begin m_r = fr; m_g = fgc; m_b = fb; end
      hit = full && !byp;
      if (sof) begin
        m_kc = m_cnt; m_cnt = hit ? 1 : 0; m_in_frame = 1;
      end else if (hit && m_in_frame && m_cnt < (1 << CNT_W) - 1) begin
        m_cnt++;
      end
    end
    q_pix.push_back({v, m_r[DW-1:0], m_g[DW-1:0], m_b[DW-1:0]});
    q_kc.push_back(m_kc);
    @(posedge clk); #1;
    iCFG_WE = 1'b0;
    e_pix = q_pix.pop_front();
    e_kc  = q_kc.pop_front();
    e_kc4 = (e_kc > 15) ? 15 : e_kc;
    g_pix = {oVALID, gsRed, gsGreen, gsBlue};
    g_kc  = int'(oKEY_CNT);
    g_kc4 = int'(oKEY_CNT4);
  endtask

  task automatic test_reset();
    #2;
    snap = {oVALID, gsRed, gsGreen, gsBlue, oKEY_CNT, oKEY_CNT4};
    n_vec++; if (snap !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", snap); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL reset_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=%0d/%0d", g_kc, g_kc4, e_kc, e_kc4); end
    end
  endtask

  task automatic test_default_key();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: step(1, 1, 'h000, 'h3FF, 'h000, 'h123, 'h045, 'h067, 0, 0, 0);
        1: step(1, 0, 'h300, 'h300, 'h300, 'h011, 'h022, 'h033, 0, 0, 0);
        default: step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL default_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL default_cnt got=%0d exp=%0d", g_kc, e_kc); end
      if (i == 2) begin
        n_vec++; if (g_pix !== {1'b1, 10'h123, 10'h045, 10'h067}) begin n_bad++; $display("FAIL default_full_bg got=%h exp=%h", g_pix, {1'b1, 10'h123, 10'h045, 10'h067}); end
      end
      if (i == 3) begin
        n_vec++; if (g_pix !== {1'b1, 10'h300, 10'h300, 10'h300}) begin n_bad++; $display("FAIL default_fg_pass got=%h exp=%h", g_pix, {1'b1, 10'h300, 10'h300, 10'h300}); end
      end
    end
  endtask

  task automatic test_cfg_shadow();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: step(1, 0, 'h010, 'h020, 'h030, 'h100, 'h100, 'h100, 1, CFG_CTRL, 3);
        1, 4: step(1, 0, 'h000, 'h100, 'h1C0, 'h100, 'h100, 'h100, 0, 0, 0);
        2: step(1, 1, 'h000, 'h100, 'h1C0, 'h100, 'h100, 'h100, 1, CFG_CTRL, 0);
        5: step(1, 1, 'h000, 'h100, 'h1C0, 'h100, 'h100, 'h100, 0, 0, 0);
        default: step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL shadow_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL shadow_cnt got=%0d exp=%0d", g_kc, e_kc); end
      if (i == 3 || i == 7) begin
        n_vec++; if (g_pix !== {1'b1, 10'h000, 10'h100, 10'h1C0}) begin n_bad++; $display("FAIL shadow_no_blend got=%h exp=%h", g_pix, {1'b1, 10'h000, 10'h100, 10'h1C0}); end
      end
      if (i == 4 || i == 6) begin
        n_vec++; if (g_pix !== {1'b1, 10'h080, 10'h100, 10'h160}) begin n_bad++; $display("FAIL shadow_blend got=%h exp=%h", g_pix, {1'b1, 10'h080, 10'h100, 10'h160}); end
      end
    end
  endtask

  task automatic test_frame_count();
    int total, need, pend;
    bit isfull;
    pend = -1;
    for (int f = 0; f < 3; f++) begin
      total = (f == 0) ? 100 : (f == 1) ? 30 : 1;
      need  = (f == 0) ? 37 : (f == 1) ? 20 : 0;
      for (int vi = 0; vi < total; vi++) begin
        if (vi != 0 && $urandom_range(0, 3) == 0) begin
          repeat (rnd(1, 2)) begin
            step(0, 0, rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), 0, 0, 0, 0, 0, 0);
            n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL frame_pix got=%h exp=%h", g_pix, e_pix); end
            n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL frame_cnt got=%0d exp=%0d", g_kc, e_kc); end
          end
        end
        isfull = (vi == 0) ? (need > 0) : (rnd(0, total - 1 - vi) < need);
        if (isfull) need--;
        if (isfull) step(1, vi == 0, rnd(0, 'hFF), rnd('h300, 'h3FF), rnd(0, 'hFF), rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), 0, 0, 0);
        else        step(1, vi == 0, rnd('h200, 'h3FF), rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), 0, 0, 0);
        n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL frame_pix got=%h exp=%h", g_pix, e_pix); end
        n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL frame_cnt got=%0d exp=%0d", g_kc, e_kc); end
        if (pend >= 0) begin
          n_vec++; if (g_kc != pend || g_kc4 != 15) begin n_bad++; $display("FAIL frame_total got=%0d/%0d exp=%0d/15", g_kc, g_kc4, pend); end
          pend = -1;
        end
        if (vi == 0 && f > 0) pend = (f == 1) ? 37 : 20;
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (g_kc != 20 || g_kc4 != 15) begin n_bad++; $display("FAIL frame_sat got=%0d/%0d exp=20/15", g_kc, g_kc4); end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_CTRL, 4);
        10: step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_CTRL, 0);
        11: step(1, 1, 'h3FF, 'h000, 'h000, 'h155, 'h0AA, 'h155, 0, 0, 0);
        12: step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        default: step(1, i == 1, 'h000, 'h3FF, 'h000, 'h155, 'h0AA, 'h155, 0, 0, 0);
      endcase
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL bypass_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL bypass_cnt got=%0d exp=%0d", g_kc, e_kc); end
      if (i == 3) begin
        n_vec++; if (g_pix !== {1'b1, 10'h000, 10'h3FF, 10'h000}) begin n_bad++; $display("FAIL bypass_fg got=%h exp=%h", g_pix, {1'b1, 10'h000, 10'h3FF, 10'h000}); end
      end
      if (i == 12) begin
        n_vec++; if (g_kc != 0 || g_kc4 != 0) begin n_bad++; $display("FAIL bypass_count got=%0d/%0d exp=0/0", g_kc, g_kc4); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_THR_HI, 'h3FF);
        1: step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_MARGIN, 'h3FF);
        2: step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_CTRL, 2);
        3: step(1, 1, 'h000, 'h3FF, 'h001, 'h200, 'h200, 'h200, 0, 0, 0);
        4: step(1, 0, 'h000, 'h3FF, 'h000, 'h200, 'h200, 'h200, 0, 0, 0);
        default: step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL ovf_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL ovf_cnt got=%0d exp=%0d", g_kc, e_kc); end
      if (i == 5) begin
        n_vec++; if (g_pix !== {1'b1, 10'h000, 10'h3FF, 10'h001}) begin n_bad++; $display("FAIL ovf_no_edge got=%h exp=%h", g_pix, {1'b1, 10'h000, 10'h3FF, 10'h001}); end
      end
      if (i == 6) begin
        n_vec++; if (g_pix !== {1'b1, 10'h100, 10'h2FF, 10'h100}) begin n_bad++; $display("FAIL ovf_edge_blend got=%h exp=%h", g_pix, {1'b1, 10'h100, 10'h2FF, 10'h100}); end
      end
    end
  endtask

  task automatic test_random();
    bit v, sof, we;
    int fr, fgc, fb;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sof = v && ($urandom_range(0, 29) == 0);
      we  = ($urandom_range(0, 11) == 0);
      fr = rnd(0, 1023); fgc = rnd(0, 1023); fb = rnd(0, 1023);
      if ($urandom_range(0, 1) == 0) begin
        fr = rnd(0, 'h180);
        if ($urandom_range(0, 1) == 0) begin fgc = rnd('h180, 'h3FF); fb = rnd(0, 'h180); end
        else                           begin fb = rnd('h180, 'h3FF); fgc = rnd(0, 'h180); end
      end
      step(v, sof, fr, fgc, fb, rnd(0, 1023), rnd(0, 1023), rnd(0, 1023), we, rnd(0, 3), rnd(0, 1023));
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL random_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL random_cnt got=%0d/%0d exp=%0d/%0d", g_kc, g_kc4, e_kc, e_kc4); end
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, CFG_CTRL, 4);
    step(1, 1, 'h000, 'h3FF, 'h000, 'h111, 'h222, 'h333, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 'h000, 'h3FF, 'h000, 'h111, 'h222, 'h333, 0, 0, 0);
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL midrst_pre_pix got=%h exp=%h", g_pix, e_pix); end
    end
    #2 rst_n = 1'b0;
    #1;
    snap = {oVALID, gsRed, gsGreen, gsBlue, oKEY_CNT, oKEY_CNT4};
    n_vec++; if (snap !== '0) begin n_bad++; $display("FAIL midrst_async got=%h exp=0", snap); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 2: step(1, 0, 'h000, 'h3FF, 'h000, 'h123, 'h045, 'h067, 0, 0, 0);
        1:    step(1, 1, 'h000, 'h3FF, 'h000, 'h123, 'h045, 'h067, 0, 0, 0);
        4:    step(1, 1, 'h3FF, 'h000, 'h000, 'h123, 'h045, 'h067, 0, 0, 0);
        default: step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      n_vec++; if (g_pix !== e_pix) begin n_bad++; $display("FAIL midrst_pix got=%h exp=%h", g_pix, e_pix); end
      n_vec++; if (g_kc != e_kc || g_kc4 != e_kc4) begin n_bad++; $display("FAIL midrst_cnt got=%0d exp=%0d", g_kc, e_kc); end
      if (i == 2) begin
        n_vec++; if (g_pix !== {1'b1, 10'h123, 10'h045, 10'h067}) begin n_bad++; $display("FAIL midrst_cfg_default got=%h exp=%h", g_pix, {1'b1, 10'h123, 10'h045, 10'h067}); end
        n_vec++; if (g_kc != 0) begin n_bad++; $display("FAIL midrst_first_frame got=%0d exp=0", g_kc); end
      end
      if (i == 5) begin
        n_vec++; if (g_kc != 2) begin n_bad++; $display("FAIL midrst_count got=%0d exp=2", g_kc); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_key();
    test_cfg_shadow();
    test_frame_count();
    test_bypass();
    test_overflow();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
